// File: rtl/chaining_record_tracker_pkg.sv
// chaining_record_tracker_pkg: shared sizes, state encoding and record layout for chaining tracking
package chaining_record_tracker_pkg;
  localparam int OFFSET_W = 9;
  localparam int GROUP_REGS = 8;
  localparam int LANES = 4;
  localparam int ELEM_W = GROUP_REGS * (1 << OFFSET_W);
  localparam int CNT_W = $clog2(ELEM_W) + 1;
  localparam int REL_W = $clog2(GROUP_REGS);
  localparam int NEW_W = $clog2(LANES + 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, COMPLETE} state_t;
  typedef struct packed {
    logic vdValid;
    logic [4:0] vd;
    logic [2:0] instIndex;
    logic [ELEM_W-1:0] elementMask;
  } record_t;
endpackage

// File: rtl/chaining_record_tracker_mask_update.sv
// chaining_mask_update: applies one write beat to the element mask and counts newly written elements
module chaining_mask_update
  import chaining_record_tracker_pkg::*;
(
  input  logic [4:0]          rel,
  input  logic [OFFSET_W-1:0] wrOffset,
  input  logic [LANES-1:0]    laneMask,
  input  logic [ELEM_W-1:0]   curMask,
  output logic [ELEM_W-1:0]   nextMask,
  output logic [NEW_W-1:0]    newCount
);
  logic inRange;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] idx [LANES];
  assign inRange = rel[4:REL_W] == '0;
  assign base = CNT_W'({rel[REL_W-1:0], wrOffset});
  for (genvar l = 0; l < LANES; l++) begin : g_idx
    assign idx[l] = base + CNT_W'(l);
  end
  // the top index bit flags lanes that ran past the end of the window
  always_comb begin
    nextMask = curMask;
    newCount = '0;
    for (int l = 0; l < LANES; l++)
      if (inRange && laneMask[l] && !idx[l][CNT_W-1] && !curMask[idx[l][CNT_W-2:0]]) begin
        nextMask[idx[l][CNT_W-2:0]] = 1'b1;
        newCount = newCount + NEW_W'(1);
      end
  end
endmodule

// File: rtl/chaining_record_tracker.sv
// chaining_record_tracker: tracks one in-flight vector instruction's destination and written-element mask
module chaining_record_tracker
  import chaining_record_tracker_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  input  logic                alloc_vd_valid,
  input  logic [4:0]          alloc_vd,
  input  logic [2:0]          alloc_inst_index,
  input  logic [CNT_W-1:0]    alloc_vl,
  input  logic                wr_valid,
  input  logic [2:0]          wr_inst_index,
  input  logic [4:0]          wr_vs,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [LANES-1:0]    wr_lane_mask,
  input  logic                retire_valid,
  input  logic [2:0]          retire_inst_index,
  output logic                record_valid,
  output logic                record_vd_valid,
  output logic [4:0]          record_vd,
  output logic [2:0]          record_inst_index,
  output logic [ELEM_W-1:0]   record_element_mask,
  output logic                record_complete
);
  state_t state;
  record_t rec;
  logic [CNT_W-1:0] vl, count, baseCount, sum, nextCount;
  logic [NEW_W-1:0] newCount;
  logic [ELEM_W-1:0] baseMask, updMask, nextMask;
  logic matchRetire, allocFire, wrAccept, effVdValid;
  logic [4:0] effVd, rel;
  logic [2:0] effIdx;
  assign matchRetire = retire_valid && state != IDLE && retire_inst_index == rec.instIndex;
  assign alloc_ready = state == IDLE || matchRetire;
  assign allocFire = alloc_valid && alloc_ready;
  // while loading, writes are judged against the incoming record on top of a cleared mask
  assign effVdValid = allocFire ? alloc_vd_valid : rec.vdValid;
  assign effVd = allocFire ? alloc_vd : rec.vd;
  assign effIdx = allocFire ? alloc_inst_index : rec.instIndex;
  assign baseMask = allocFire ? '0 : rec.elementMask;
  assign baseCount = allocFire ? '0 : count;
  assign wrAccept = wr_valid && (state != IDLE || allocFire) && wr_inst_index == effIdx && effVdValid;
  assign rel = wr_vs - effVd;
  chaining_mask_update u_update (
    .rel(rel),
    .wrOffset(wr_offset),
    .laneMask(wr_lane_mask),
    .curMask(baseMask),
    .nextMask(updMask),
    .newCount(newCount)
  );
  assign sum = baseCount + CNT_W'(newCount);
  assign nextCount = !wrAccept ? baseCount : sum > CNT_W'(ELEM_W) ? CNT_W'(ELEM_W) : sum;
  assign nextMask = wrAccept ? updMask : baseMask;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      rec <= '0;
      vl <= '0;
      count <= '0;
    end else if (allocFire) begin
      state <= nextCount >= alloc_vl ? COMPLETE : ACTIVE;
      rec <= '{vdValid: alloc_vd_valid, vd: alloc_vd, instIndex: alloc_inst_index, elementMask: nextMask};
      vl <= alloc_vl;
      count <= nextCount;
    end else if (matchRetire) begin
      state <= IDLE;
      rec <= '0;
      vl <= '0;
      count <= '0;
    end else if (state != IDLE) begin
      rec.elementMask <= nextMask;
      count <= nextCount;
      if (nextCount >= vl) state <= COMPLETE;
    end
  end
  assign record_valid = state != IDLE;
  assign record_complete = state == COMPLETE;
  assign record_vd_valid = rec.vdValid;
  assign record_vd = rec.vd;
  assign record_inst_index = rec.instIndex;
  assign record_element_mask = rec.elementMask;
endmodule

// File: tb/tb_chaining_record_tracker.sv
// tb_chaining_record_tracker: directed plus random stimulus against a set-based reference model
module tb_chaining_record_tracker;
  import chaining_record_tracker_pkg::*;
  logic clock = 1'b0;
  logic reset, alloc_valid, alloc_ready, alloc_vd_valid, wr_valid, retire_valid;
  logic [4:0] alloc_vd, wr_vs;
  logic [2:0] alloc_inst_index, wr_inst_index, retire_inst_index;
  logic [CNT_W-1:0] alloc_vl;
  logic [OFFSET_W-1:0] wr_offset;
  logic [LANES-1:0] wr_lane_mask;
  logic record_valid, record_vd_valid, record_complete;
  logic [4:0] record_vd;
  logic [2:0] record_inst_index;
  logic [ELEM_W-1:0] record_element_mask;
  int errors = 0, checks = 0;
  bit mValid;
  logic mVdValid;
  logic [4:0] mVd;
  logic [2:0] mIdx;
  int mVl;
  bit written [int];

  chaining_record_tracker dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_vd_valid(alloc_vd_valid),
    .alloc_vd(alloc_vd), .alloc_inst_index(alloc_inst_index), .alloc_vl(alloc_vl),
    .wr_valid(wr_valid), .wr_inst_index(wr_inst_index), .wr_vs(wr_vs),
    .wr_offset(wr_offset), .wr_lane_mask(wr_lane_mask),
    .retire_valid(retire_valid), .retire_inst_index(retire_inst_index),
    .record_valid(record_valid), .record_vd_valid(record_vd_valid), .record_vd(record_vd),
    .record_inst_index(record_inst_index), .record_element_mask(record_element_mask),
    .record_complete(record_complete)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    reset = 0; alloc_valid = 0; alloc_vd_valid = 0; alloc_vd = 0; alloc_inst_index = 0; alloc_vl = 0;
    wr_valid = 0; wr_inst_index = 0; wr_vs = 0; wr_offset = 0; wr_lane_mask = 0;
    retire_valid = 0; retire_inst_index = 0;
  endtask

  function automatic bit expReady();
    return !mValid || (retire_valid && retire_inst_index == mIdx);
  endfunction

  task automatic modelStep();
    bit ret, fire;
    int rel, e;
    ret = mValid && retire_valid && retire_inst_index == mIdx;
    fire = alloc_valid && expReady();
    if (reset || (ret && !fire)) begin
      mValid = 0; mVdValid = 0; mVd = 0; mIdx = 0; mVl = 0; written.delete();
      return;
    end
    if (fire) begin
      mValid = 1; mVdValid = alloc_vd_valid; mVd = alloc_vd; mIdx = alloc_inst_index;
      mVl = int'(alloc_vl); written.delete();
    end
    if (mValid && wr_valid && wr_inst_index == mIdx && mVdValid) begin
      rel = (int'(wr_vs) - int'(mVd) + 32) % 32;
      if (rel < GROUP_REGS)
        for (int l = 0; l < LANES; l++) begin
          e = rel * 512 + int'(wr_offset) + l;
          if (wr_lane_mask[l] && e < ELEM_W) written[e] = 1;
        end
    end
  endtask

  task automatic checkOutputs();
    logic [ELEM_W-1:0] m;
    int diff;
    m = '0;
    foreach (written[k]) m[k] = 1'b1;
    chk("record_valid", 32'(record_valid), 32'(mValid));
    chk("record_vd_valid", 32'(record_vd_valid), 32'(mVdValid));
    chk("record_vd", 32'(record_vd), 32'(mVd));
    chk("record_inst_index", 32'(record_inst_index), 32'(mIdx));
    chk("record_complete", 32'(record_complete), 32'(mValid && written.num() >= mVl));
    checks++;
    assert (record_element_mask === m) else begin
      errors++;
      diff = -1;
      for (int i = ELEM_W - 1; i >= 0; i--) if (record_element_mask[i] !== m[i]) diff = i;
      $error("FAIL record_element_mask: observed popcount %0d expected %0d, first differing bit %0d",
             $countones(record_element_mask), written.num(), diff);
    end
  endtask

  task automatic cycle();
    #1;
    chk("alloc_ready", 32'(alloc_ready), 32'(expReady()));
    modelStep();
    @(posedge clock);
    #1;
    checkOutputs();
    idleInputs();
  endtask

  task automatic doAlloc(input logic [4:0] vd, input logic [2:0] idx, input int vl);
    alloc_valid = 1; alloc_vd_valid = 1; alloc_vd = vd; alloc_inst_index = idx; alloc_vl = CNT_W'(vl);
  endtask

  task automatic doWrite(input logic [2:0] idx, input logic [4:0] vs, input int off, input logic [3:0] lanes);
    wr_valid = 1; wr_inst_index = idx; wr_vs = vs; wr_offset = OFFSET_W'(off); wr_lane_mask = lanes;
  endtask

  initial begin
    idleInputs();
    mValid = 0; mVdValid = 0; mVd = 0; mIdx = 0; mVl = 0;
    reset = 1;
    cycle();
    reset = 1;
    cycle();
    cycle();
    chk("reset_ready", 32'(alloc_ready), 32'd1);
    chk("reset_mask_zero", 32'(record_element_mask == '0), 32'd1);
    doAlloc(5'd8, 3'd2, 8);
    cycle();
    chk("alloc_vd8", 32'(record_vd), 32'd8);
    doWrite(3'd2, 5'd9, 0, 4'hF);
    cycle();
    chk("bits_512_515", 32'(record_element_mask[515:512]), 32'hF);
    doWrite(3'd2, 5'd9, 0, 4'hF);
    cycle();
    doWrite(3'd2, 5'd9, 0, 4'hF);
    cycle();
    chk("rewrite_not_complete", 32'(record_complete), 32'd0);
    doWrite(3'd2, 5'd8, 4, 4'hF);
    cycle();
    chk("complete_at_8", 32'(record_complete), 32'd1);
    doWrite(3'd3, 5'd8, 16, 4'hF);
    cycle();
    doWrite(3'd2, 5'd16, 0, 4'hF);
    cycle();
    doWrite(3'd2, 5'd7, 0, 4'hF);
    cycle();
    chk("dropped_popcount", $countones(record_element_mask), 32'd8);
    doWrite(3'd2, 5'd15, 510, 4'hF);
    cycle();
    chk("window_end_lanes", 32'(record_element_mask[4095:4094]), 32'h3);
    retire_valid = 1; retire_inst_index = 3'd2;
    doAlloc(5'd0, 3'd3, 4);
    doWrite(3'd3, 5'd0, 0, 4'h3);
    cycle();
    chk("realloc_idx", 32'(record_inst_index), 32'd3);
    chk("realloc_bits", 32'(record_element_mask[3:0]), 32'h3);
    chk("realloc_active", 32'(record_complete), 32'd0);
    retire_valid = 1; retire_inst_index = 3'd5;
    cycle();
    retire_valid = 1; retire_inst_index = 3'd3;
    doAlloc(5'd4, 3'd1, 0);
    cycle();
    chk("vl0_complete", 32'(record_complete), 32'd1);
    retire_valid = 1; retire_inst_index = 3'd1;
    cycle();
    doAlloc(5'd2, 3'd6, 20);
    cycle();
    doWrite(3'd6, 5'd3, 7, 4'h5);
    cycle();
    reset = 1;
    doWrite(3'd6, 5'd3, 9, 4'hF);
    cycle();
    chk("reset_idle", 32'(record_valid), 32'd0);
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      alloc_valid = ($urandom_range(0, 3) == 0);
      alloc_vd_valid = ($urandom_range(0, 7) != 0);
      alloc_vd = 5'($urandom);
      alloc_inst_index = 3'($urandom);
      alloc_vl = CNT_W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 4096) : $urandom_range(0, 12));
      retire_valid = ($urandom_range(0, 9) == 0);
      retire_inst_index = $urandom_range(0, 1) ? mIdx : 3'($urandom);
      wr_valid = $urandom_range(0, 1);
      wr_inst_index = $urandom_range(0, 3) != 0 ? (alloc_valid ? alloc_inst_index : mIdx) : 3'($urandom);
      wr_vs = (alloc_valid ? alloc_vd : mVd) + 5'($urandom_range(0, 9)) - 5'($urandom_range(0, 1));
      wr_offset = $urandom_range(0, 1) ? OFFSET_W'($urandom_range(0, 8)) : OFFSET_W'($urandom);
      wr_lane_mask = 4'($urandom);
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
